// File: rtl/vert_avg_engine.sv
// vert_avg_engine
// ---------------
// Reduces consecutive groups of GROUP_SIZE signed words from a source RAM
// into one word each and writes the results to a destination RAM. Each
// result is either the floor mean of the group (mode 0) or the group sum
// clamped to the signed DATA_WIDTH range (mode 1).
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE
// (busy=0); it is ignored while busy=1. Each accepted operation ends with a
// single-cycle done pulse, and busy drops in the cycle after that pulse.
// The source RAM is synchronous: ri_do is valid in the cycle after ri_en=1.
// The destination RAM writes on every cycle with wo_en=1.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, mode         operation request, 0 = mean / 1 = saturated sum
//   src_base, dst_base  first source / destination word address
//   group_count         number of output words to produce
//   ri_en, ri_addr      source RAM read request
//   ri_do               source RAM read data
//   wo_en, wo_we        destination RAM enable and byte write enables
//   wo_addr, wo_di      destination RAM address and write data
//   busy, done          status: operation in progress, completion pulse
//   word_count          words written in the current or last operation
module vert_avg_engine #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int GROUP_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_WIDTH-1:0]   src_base,
    input  logic [ADDR_WIDTH-1:0]   dst_base,
    input  logic [ADDR_WIDTH-1:0]   group_count,
    output logic                    ri_en,
    output logic [ADDR_WIDTH-1:0]   ri_addr,
    input  logic [DATA_WIDTH-1:0]   ri_do,
    output logic                    wo_en,
    output logic [DATA_WIDTH/8-1:0] wo_we,
    output logic [ADDR_WIDTH-1:0]   wo_addr,
    output logic [DATA_WIDTH-1:0]   wo_di,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             word_count
);

    localparam int LOG2G = $clog2(GROUP_SIZE);
    localparam int ACC_W = DATA_WIDTH + LOG2G;
    localparam int NB    = DATA_WIDTH / 8;

    localparam logic [LOG2G-1:0]        K_LAST  = LOG2G'(GROUP_SIZE - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(LOG2G + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(LOG2G + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state_q;

    // Operation parameters captured at the accepted start.
    logic                     mode_q;
    logic [ADDR_WIDTH-1:0]    src_base_q;
    logic [ADDR_WIDTH-1:0]    dst_base_q;
    logic [ADDR_WIDTH-1:0]    gc_q;

    // Position within the operation: group index and read index in group.
    logic [ADDR_WIDTH-1:0]    grp_q;
    logic [LOG2G-1:0]         k_q;

    logic signed [ACC_W-1:0]  acc_q;

    // Registered outputs.
    logic                     ri_en_q;
    logic [ADDR_WIDTH-1:0]    ri_addr_q;
    logic                     wo_en_q;
    logic [NB-1:0]            wo_we_q;
    logic [ADDR_WIDTH-1:0]    wo_addr_q;
    logic [DATA_WIDTH-1:0]    wo_di_q;
    logic                     busy_q;
    logic                     done_q;
    logic [31:0]              word_count_q;

    // Combinational helpers.
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  mean_w;
    logic [DATA_WIDTH-1:0]    result_d;
    logic [ADDR_WIDTH-1:0]    grp_inc;
    logic [ADDR_WIDTH-1:0]    addr_in_grp;
    logic [ADDR_WIDTH-1:0]    addr_next_grp;

    always_comb begin
        // Running sum including the word returned by the previous read.
        acc_d  = acc_q + {{LOG2G{ri_do[DATA_WIDTH-1]}}, ri_do};
        // Arithmetic shift of a signed value floors toward negative infinity;
        // the mean of DATA_WIDTH-bit values always fits DATA_WIDTH bits.
        mean_w = acc_d >>> LOG2G;

        result_d = mean_w[DATA_WIDTH-1:0];
        if (mode_q) begin
            if (acc_d > SAT_MAX) begin
                result_d = SAT_MAX[DATA_WIDTH-1:0];
            end else if (acc_d < SAT_MIN) begin
                result_d = SAT_MIN[DATA_WIDTH-1:0];
            end else begin
                result_d = acc_d[DATA_WIDTH-1:0];
            end
        end

        grp_inc       = grp_q + ADDR_WIDTH'(1);
        // Addresses wrap naturally at 2^ADDR_WIDTH.
        addr_in_grp   = src_base_q + (grp_q << LOG2G) + ADDR_WIDTH'(k_q) + ADDR_WIDTH'(1);
        addr_next_grp = src_base_q + (grp_inc << LOG2G);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            gc_q         <= '0;
            grp_q        <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            ri_en_q      <= 1'b0;
            ri_addr_q    <= '0;
            wo_en_q      <= 1'b0;
            wo_we_q      <= '0;
            wo_addr_q    <= '0;
            wo_di_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q       <= mode;
                        src_base_q   <= src_base;
                        dst_base_q   <= dst_base;
                        gc_q         <= group_count;
                        word_count_q <= '0;
                        grp_q        <= '0;
                        k_q          <= '0;
                        acc_q        <= '0;
                        busy_q       <= 1'b1;
                        if (group_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_READ;
                            ri_en_q   <= 1'b1;
                            ri_addr_q <= src_base;
                        end
                    end
                end

                S_READ: begin
                    // The first read cycle has no returned data yet.
                    if (k_q != '0) begin
                        acc_q <= acc_d;
                    end
                    if (k_q == K_LAST) begin
                        state_q <= S_DRAIN;
                        ri_en_q <= 1'b0;
                        k_q     <= '0;
                    end else begin
                        k_q       <= k_q + LOG2G'(1);
                        ri_addr_q <= addr_in_grp;
                    end
                end

                S_DRAIN: begin
                    // Last word of the group arrives here; result is final.
                    acc_q     <= acc_d;
                    state_q   <= S_WRITE;
                    wo_en_q   <= 1'b1;
                    wo_we_q   <= '1;
                    wo_addr_q <= dst_base_q + grp_q;
                    wo_di_q   <= result_d;
                end

                S_WRITE: begin
                    wo_en_q      <= 1'b0;
                    wo_we_q      <= '0;
                    word_count_q <= word_count_q + 32'd1;
                    if (grp_inc == gc_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= S_READ;
                        grp_q     <= grp_inc;
                        acc_q     <= '0;
                        ri_en_q   <= 1'b1;
                        ri_addr_q <= addr_next_grp;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ri_en      = ri_en_q;
    assign ri_addr    = ri_addr_q;
    assign wo_en      = wo_en_q;
    assign wo_we      = wo_we_q;
    assign wo_addr    = wo_addr_q;
    assign wo_di      = wo_di_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_vert_avg_engine.sv
// Testbench for vert_avg_engine (GROUP_SIZE=4, DATA_WIDTH=32, ADDR_WIDTH=11).
module tb_vert_avg_engine;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int G     = 4;
    localparam int DEPTH = 2048;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW-1:0] group_count = '0;
    logic          ri_en;
    logic [AW-1:0] ri_addr;
    logic [DW-1:0] ri_do = '0;
    logic          wo_en;
    logic [3:0]    wo_we;
    logic [AW-1:0] wo_addr;
    logic [DW-1:0] wo_di;
    logic          busy;
    logic          done;
    logic [31:0]   word_count;

    always #5 clk = ~clk;

    vert_avg_engine #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .GROUP_SIZE(G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .group_count(group_count),
        .ri_en      (ri_en),
        .ri_addr    (ri_addr),
        .ri_do      (ri_do),
        .wo_en      (wo_en),
        .wo_we      (wo_we),
        .wo_addr    (wo_addr),
        .wo_di      (wo_di),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    // ---------------- RAM models and monitor ----------------
    logic [DW-1:0] src_mem [DEPTH];
    logic          dst_wr  [DEPTH];

    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    int            busy_cnt;
    int            bad_we;

    always @(posedge clk) begin
        if (ri_en) ri_do <= src_mem[ri_addr];
    end

    always @(negedge clk) begin
        if (ri_en) rd_log.push_back(ri_addr);
        if (wo_en) begin
            got_addr.push_back(wo_addr);
            got_data.push_back(wo_di);
            dst_wr[wo_addr] = 1'b1;
            if (wo_we !== 4'hF) bad_we++;
        end else if (wo_we !== 4'h0) begin
            bad_we++;
        end
        if (busy) busy_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: sum the group as plain integers, then take the floor mean
    // or clamp the sum.
    task automatic build_expected(input logic m, input int sb, input int db, input int gc);
        exp_q.delete();
        exp_addr_q.delete();
        for (int g = 0; g < gc; g++) begin
            longint sum;
            longint q;
            logic [DW-1:0] r;
            sum = 0;
            for (int k = 0; k < G; k++) begin
                int v;
                v = int'(src_mem[(sb + g * G + k) % DEPTH]);
                sum += v;
            end
            if (m == 1'b0) begin
                q = sum / G;
                if (sum < 0 && (sum % G) != 0) q = q - 1;
                r = q[DW-1:0];
            end else begin
                if (sum > 64'sd2147483647) r = 32'h7FFF_FFFF;
                else if (sum < -64'sd2147483648) r = 32'h8000_0000;
                else r = sum[DW-1:0];
            end
            exp_q.push_back(r);
            exp_addr_q.push_back(AW'((db + g) % DEPTH));
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        got_addr.delete();
        got_data.delete();
        busy_cnt = 0;
        bad_we = 0;
        for (int i = 0; i < DEPTH; i++) dst_wr[i] = 1'b0;
    endtask

    task automatic set4(input int a, input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                        input logic [DW-1:0] v2, input logic [DW-1:0] v3);
        src_mem[a % DEPTH]       = v0;
        src_mem[(a + 1) % DEPTH] = v1;
        src_mem[(a + 2) % DEPTH] = v2;
        src_mem[(a + 3) % DEPTH] = v3;
    endtask

    // ---------------- driver ----------------
    // Runs one operation and checks latency, busy, writes and read addresses.
    // With poke set, a second start with different inputs is pulsed in READ.
    task automatic run_op(input logic m, input int sb, input int db, input int gc,
                          input bit poke, input string tag);
        int n;
        int lat;
        clear_logs();
        build_expected(m, sb, db, gc);
        @(negedge clk);
        mode = m;
        src_base = AW'(sb);
        dst_base = AW'(db);
        group_count = AW'(gc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        lat = -1;
        while (n <= 2000) begin
            if (poke && n == 2) begin
                start = 1'b1;
                mode = ~m;
                src_base = AW'($urandom_range(0, DEPTH - 1));
                dst_base = AW'($urandom_range(0, DEPTH - 1));
                group_count = 7;
            end
            if (poke && n == 3) start = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(gc * (G + 2) + 1));
        @(posedge clk);
        #1;
        check({tag, ".busy_after"}, 64'(busy), 64'd0);
        check({tag, ".done_after"}, 64'(done), 64'd0);
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(gc * (G + 2) + 1));
        check({tag, ".word_count"}, 64'(word_count), 64'(gc));
        check({tag, ".n_writes"}, 64'(got_data.size()), 64'(exp_q.size()));
        check({tag, ".we"}, 64'(bad_we), 64'd0);
        for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
            check({tag, ".wdata"}, 64'(got_data[i]), 64'(exp_q[i]));
            check({tag, ".waddr"}, 64'(got_addr[i]), 64'(exp_addr_q[i]));
        end
        check({tag, ".n_reads"}, 64'(rd_log.size()), 64'(gc * G));
        for (int i = 0; i < rd_log.size() && i < gc * G; i++) begin
            check({tag, ".raddr"}, 64'(rd_log[i]), 64'((sb + i) % DEPTH));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".ri_en"}, 64'(ri_en), 64'd0);
        check({tag, ".ri_addr"}, 64'(ri_addr), 64'd0);
        check({tag, ".wo_en"}, 64'(wo_en), 64'd0);
        check({tag, ".wo_we"}, 64'(wo_we), 64'd0);
        check({tag, ".wo_addr"}, 64'(wo_addr), 64'd0);
        check({tag, ".wo_di"}, 64'(wo_di), 64'd0);
        check({tag, ".word_count"}, 64'(word_count), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) src_mem[i] = $urandom;
        clear_logs();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("idle");

        // Mean of one group.
        set4(0, 32'd1, 32'd2, 32'd3, 32'd6);
        run_op(1'b0, 0, 100, 1, 1'b0, "mean");
        if (got_data.size() > 0) check("mean.value", 64'(got_data[0]), 64'd3);

        // Negative floor, then two groups.
        set4(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
        run_op(1'b0, 0, 100, 1, 1'b0, "negfloor");
        if (got_data.size() > 0) check("negfloor.value", 64'(got_data[0]), 64'hFFFF_FFFD);
        set4(4, 32'd8, 32'd8, 32'd8, 32'd8);
        run_op(1'b0, 0, 100, 2, 1'b0, "twogrp");
        if (got_data.size() > 1) check("twogrp.value1", 64'(got_data[1]), 64'd8);

        // Saturated sums.
        set4(200, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op(1'b1, 200, 400, 1, 1'b0, "sat_pos");
        if (got_data.size() > 0) check("sat_pos.value", 64'(got_data[0]), 64'h7FFF_FFFF);
        set4(200, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        run_op(1'b1, 200, 400, 1, 1'b0, "sat_neg");
        if (got_data.size() > 0) check("sat_neg.value", 64'(got_data[0]), 64'h8000_0000);
        set4(200, 32'd1, 32'd2, 32'd3, 32'd4);
        run_op(1'b1, 200, 400, 1, 1'b0, "sat_mid");
        if (got_data.size() > 0) check("sat_mid.value", 64'(got_data[0]), 64'd10);

        // Zero groups.
        run_op(1'b0, 5, 6, 0, 1'b0, "zero");

        // Address wrap with an ignored second start.
        set4(2046, 32'd10, 32'hFFFF_FFF0, 32'd7, 32'd1);
        run_op(1'b0, 2046, 300, 1, 1'b1, "wrap");
        if (rd_log.size() == 4) begin
            check("wrap.a0", 64'(rd_log[0]), 64'd2046);
            check("wrap.a3", 64'(rd_log[3]), 64'd1);
        end

        // Reset during READ of the second group.
        begin
            int db;
            db = 500;
            clear_logs();
            set4(40, 32'd4, 32'd4, 32'd4, 32'd8);
            build_expected(1'b0, 40, db, 3);
            @(negedge clk);
            mode = 1'b0;
            src_base = AW'(40);
            dst_base = AW'(db);
            group_count = AW'(3);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (7) @(posedge clk);
            #1;
            check("rstmid.busy_before", 64'(busy), 64'd1);
            rst = 1'b1;
            #1;
            check_all_zero("rstmid");
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("rstmid.n_writes", 64'(got_data.size()), 64'd1);
            if (got_data.size() > 0) check("rstmid.wdata0", 64'(got_data[0]), 64'(exp_q[0]));
            check("rstmid.dst1", 64'(dst_wr[db + 1]), 64'd0);
            check("rstmid.dst2", 64'(dst_wr[db + 2]), 64'd0);
            check("rstmid.idle", 64'(busy), 64'd0);
        end
        run_op(1'b1, 40, 500, 3, 1'b0, "after_rst");

        // Randomized operations.
        for (int t = 0; t < 20; t++) begin
            int sb;
            int db;
            int gc;
            logic m;
            sb = $urandom_range(0, DEPTH - 1);
            db = $urandom_range(0, DEPTH - 1);
            gc = $urandom_range(1, 5);
            m = 1'($urandom_range(0, 1));
            for (int i = 0; i < gc * G; i++) begin
                case ($urandom_range(0, 3))
                    0: src_mem[(sb + i) % DEPTH] = 32'h7FFF_FFFF;
                    1: src_mem[(sb + i) % DEPTH] = 32'h8000_0000;
                    default: src_mem[(sb + i) % DEPTH] = $urandom;
                endcase
            end
            run_op(m, sb, db, gc, 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vert_avg_engine.md
VERT_AVG_ENGINE -- requirements
Module: vert_avg_engine

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the word-address width of both RAM ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width; multiple of 8.
REQ-003 Parameter GROUP_SIZE, default 4, SHALL set the input words reduced per output word; power of two, 2..64.
REQ-004 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle operation request.
- mode  in  1  0 = mean, 1 = saturated sum.
- src_base  in  ADDR_WIDTH  first input word address.
- dst_base  in  ADDR_WIDTH  first output word address.
- group_count  in  ADDR_WIDTH  number of output words to produce.
- ri_en  out  1  source RAM read enable.
- ri_addr  out  ADDR_WIDTH  source RAM address.
- ri_do  in  DATA_WIDTH  source RAM read data.
- wo_en  out  1  destination RAM enable.
- wo_we  out  DATA_WIDTH/8  destination byte write enables.
- wo_addr  out  ADDR_WIDTH  destination RAM address.
- wo_di  out  DATA_WIDTH  destination write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- word_count  out  32  output words written in the current or last operation.

Function
REQ-005 Source RAM SHALL be treated as synchronous: ri_do is valid the cycle after ri_en=1 with that ri_addr.
REQ-006 FSM states SHALL be IDLE, READ, DRAIN, WRITE, DONE.
REQ-007 In IDLE, start=1 SHALL latch mode, src_base, dst_base and group_count, clear word_count, and go to DONE if group_count=0, else to READ.
REQ-008 start SHALL be ignored outside IDLE. Latched values SHALL NOT change until the next accepted start.
REQ-009 READ SHALL last GROUP_SIZE cycles. Cycle k of group g SHALL drive ri_en=1 and ri_addr=src_base+g*GROUP_SIZE+k, modulo 2^ADDR_WIDTH.
REQ-010 The accumulator SHALL be signed, DATA_WIDTH+log2(GROUP_SIZE) bits wide, and cleared at the start of each group.
REQ-011 The accumulator SHALL add sign-extended ri_do in each cycle following a read issue, covering READ cycles 1..GROUP_SIZE-1 and DRAIN.
REQ-012 DRAIN SHALL last one cycle with ri_en=0, then go to WRITE.
REQ-013 WRITE SHALL last one cycle and drive wo_en=1, wo_we all ones, wo_addr=dst_base+g modulo 2^ADDR_WIDTH, and wo_di=result.
REQ-014 In WRITE, word_count SHALL increment by 1.
REQ-015 After WRITE, the FSM SHALL go to READ for the next group if groups remain, else to DONE.
REQ-016 Mode 0 result SHALL be the accumulator arithmetically shifted right by log2(GROUP_SIZE), rounding toward negative infinity, truncated to DATA_WIDTH bits (always in range).
REQ-017 Mode 1 result SHALL be the accumulator clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-018 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Outside READ, ri_en SHALL be 0. Outside WRITE, wo_en and wo_we SHALL be 0.
REQ-021 Per-operation latency from the start cycle to the done pulse SHALL be group_count*(GROUP_SIZE+2)+1 cycles.
REQ-022 word_count SHALL hold its value after DONE until the next accepted start.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE.
REQ-024 rst=1 SHALL immediately force to 0: busy, done, ri_en, ri_addr, wo_en, wo_we, wo_addr, wo_di, word_count, the accumulator and all latched inputs.
REQ-025 Reset asserted mid-operation SHALL abort with no further RAM writes. Writes already completed remain in the destination RAM.

Verification (GROUP_SIZE=4, DATA_WIDTH=32, ADDR_WIDTH=11)
REQ-026 Mean: src[0..3]=1,2,3,6; src_base=0, dst_base=100, group_count=1, mode=0 -> dst[100]=3; word_count=1; done 7 cycles after start; busy falls with done.
REQ-027 Negative floor: src[0..3]=-1,-2,-3,-4, mode=0 -> dst=-3 (0xFFFFFFFD). Two groups, src[4..7]=8,8,8,8 -> dst[101]=8; word_count=2.
REQ-028 Saturation: four 0x7FFFFFFF, mode=1 -> 0x7FFFFFFF. Four 0x80000000, mode=1 -> 0x80000000. Values 1,2,3,4, mode=1 -> 10.
REQ-029 Zero groups: group_count=0 -> no ri_en or wo_en; busy high exactly 1 cycle; done pulse 1 cycle after start; word_count=0.
REQ-030 Wrap and ignored start: src_base=2046 -> ri_addr sequence 2046,2047,0,1. A second start pulse during READ has no effect on addresses or results.
REQ-031 Reset mid-operation: group_count=3, rst pulsed during READ of group 2 -> all outputs 0 within the reset cycle; dst[dst_base+1], dst[dst_base+2] unwritten; a subsequent start runs normally.
